// File: rtl/video_pattern_tx.sv
// video_pattern_tx: DE/HSYNC/VSYNC timing generator with selectable 24-bit RGB test patterns.
// Define VIDEO_PATTERN_TX_FRAME_CNT_EN to add the frame_cnt port and a scrolling grey ramp.
module video_pattern_tx #(
    parameter int          H_ACTIVE    = 64,
    parameter int          H_FP        = 4,
    parameter int          H_SYNC      = 8,
    parameter int          H_BP        = 4,
    parameter int          V_ACTIVE    = 32,
    parameter int          V_FP        = 2,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 2,
    parameter logic [23:0] SOLID_COLOR = 24'hFF0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        de_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic [23:0] pixel_out,
    output logic        frame_start
`ifdef VIDEO_PATTERN_TX_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int BW = $clog2(BAR_W + 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [1:0]    pat;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar_idx;
    logic          active, frame_end, start_frame;
    logic [7:0]    ramp;
    logic [23:0]   bar_rgb, pix;
`ifdef VIDEO_PATTERN_TX_FRAME_CNT_EN
    logic [15:0]   fcnt;
    logic          started;
`endif

    always_comb begin
        active      = state == RUN && h_cnt <= H_ACT_LAST && v_cnt <= V_ACT_LAST;
        frame_end   = state == RUN && h_cnt == H_LAST && v_cnt == V_LAST;
        start_frame = enable && (state == IDLE || frame_end);
        // bar order white..black maps to R=~i[1], G=~i[2], B=~i[0]
        bar_rgb     = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
`ifdef VIDEO_PATTERN_TX_FRAME_CNT_EN
        ramp        = 8'(h_cnt) + fcnt[7:0];
`else
        ramp        = 8'(h_cnt);
`endif
        pix = pat == 2'd0 ? bar_rgb :
              pat == 2'd1 ? {3{ramp}} :
              pat == 2'd2 ? {24{|((16'(h_cnt) ^ 16'(v_cnt)) & 16'h0008)}} :
                            SOLID_COLOR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pat         <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            de_out      <= 1'b0;
            h_sync_out  <= 1'b0;
            v_sync_out  <= 1'b0;
            pixel_out   <= '0;
            frame_start <= 1'b0;
        end else begin
            state <= (state == RUN && !frame_end) || enable ? RUN : IDLE;
            pat   <= start_frame ? pattern_sel : pat;
            h_cnt <= state == RUN && h_cnt != H_LAST ? h_cnt + 1'b1 : '0;
            v_cnt <= state != RUN || frame_end ? '0 : h_cnt == H_LAST ? v_cnt + 1'b1 : v_cnt;
            if (state != RUN || h_cnt == H_LAST) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (h_cnt <= H_ACT_LAST) begin
                bar_cnt <= bar_cnt == BAR_LAST ? '0 : bar_cnt + 1'b1;
                bar_idx <= bar_idx + 3'(bar_cnt == BAR_LAST);
            end
            de_out      <= active;
            h_sync_out  <= state == RUN && h_cnt >= HS_FIRST && h_cnt <= HS_LAST;
            v_sync_out  <= state == RUN && v_cnt >= VS_FIRST && v_cnt <= VS_LAST;
            pixel_out   <= active ? pix : '0;
            frame_start <= state == RUN && h_cnt == '0 && v_cnt == '0;
        end
    end

`ifdef VIDEO_PATTERN_TX_FRAME_CNT_EN
    // fcnt steps with the counters; frame_cnt is its copy aligned to the other outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt      <= '0;
            started   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (start_frame) begin
                started <= 1'b1;
                fcnt    <= fcnt + 16'(started);
            end
            frame_cnt <= fcnt;
        end
    end
`endif
endmodule

// File: tb/tb_video_pattern_tx.sv
// tb_video_pattern_tx: directed frame-by-frame checks of timing, patterns, enable and reset.
module tb_video_pattern_tx;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        de_out, h_sync_out, v_sync_out, frame_start;
    logic [23:0] pixel_out;
`ifdef VIDEO_PATTERN_TX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] fc0;
`endif
    int          vectors = 0, miscompares = 0;
    logic        de_a [192], hs_a [192], vs_a [192], fs_a [192];
    logic [23:0] px_a [192];
    int          nde, nhs, nvs, nfs, npx, vs_first, hs_first, bad_blank;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 clk = ~clk;

    video_pattern_tx #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SOLID_COLOR(24'hFF0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .de_out(de_out),
        .h_sync_out(h_sync_out),
        .v_sync_out(v_sync_out),
        .pixel_out(pixel_out),
        .frame_start(frame_start)
`ifdef VIDEO_PATTERN_TX_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({de_out, h_sync_out, v_sync_out, frame_start, pixel_out});
    endfunction

    // samples 192 consecutive output cycles; optionally changes pattern_sel/enable after cycle sel_k/en_k
    task automatic grab(input int sel_k, input logic [1:0] sel_v, input int en_k, input logic en_v);
        nde = 0; nhs = 0; nvs = 0; nfs = 0; npx = 0;
        vs_first = -1; hs_first = -1; bad_blank = 0;
        for (int k = 0; k < 192; k++) begin
            @(negedge clk);
            de_a[k] = de_out; hs_a[k] = h_sync_out; vs_a[k] = v_sync_out;
            fs_a[k] = frame_start; px_a[k] = pixel_out;
            nde += int'(de_out); nhs += int'(h_sync_out);
            nvs += int'(v_sync_out); nfs += int'(frame_start);
            npx += int'(pixel_out != 24'h0);
            if (v_sync_out && vs_first < 0) vs_first = k;
            if (h_sync_out && hs_first < 0) hs_first = k;
            if (!de_out && pixel_out != 24'h0) bad_blank++;
`ifdef VIDEO_PATTERN_TX_FRAME_CNT_EN
            if (k == 0) fc0 = frame_cnt;
`endif
            if (k == sel_k) pattern_sel = sel_v;
            if (k == en_k) enable = en_v;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_outs", outs(), 32'h0);
        // frame 1: grey ramp, timing
        pattern_sel = 2'd1;
        enable = 1'b1;
        @(negedge clk);
        chk("pre_first_outs", outs(), 32'h0);
        grab(60, 2'd0, -1, 1'b1);
        chk("f1_fs_first", 32'(fs_a[0]), 32'h1);
        chk("f1_nfs", nfs, 1);
        chk("f1_nde", nde, 64);
        chk("f1_nhs", nhs, 24);
        chk("f1_hs_first", hs_first, 18);
        chk("f1_hs_blank_line", 32'(hs_a[114]), 32'h1);
        chk("f1_nvs", nvs, 48);
        chk("f1_vs_first", vs_first, 120);
        chk("f1_vs_end", 32'({vs_a[167], vs_a[168]}), 32'b10);
        chk("f1_ramp_x5", 32'(px_a[5]), 32'h050505);
        chk("f1_ramp_l1_x15", 32'(px_a[39]), 32'h0F0F0F);
        chk("f1_ramp_after_sel", 32'(px_a[77]), 32'h050505);
        chk("f1_blank_pix", bad_blank, 0);
        // frame 2: colour bars
        grab(150, 2'd2, -1, 1'b1);
        chk("f2_fs_first", 32'(fs_a[0]), 32'h1);
        chk("f2_nfs", nfs, 1);
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < 8; b++) begin
                chk("f2_bar_a", 32'(px_a[l*24 + b*2]), 32'(bars[b]));
                chk("f2_bar_b", 32'(px_a[l*24 + b*2 + 1]), 32'(bars[b]));
            end
        chk("f2_blank_pix", bad_blank, 0);
        // frame 3: checkerboard, switch to solid mid-frame
        grab(50, 2'd3, -1, 1'b1);
        chk("f3_chk_x3", 32'(px_a[3]), 32'h0);
        chk("f3_chk_x8", 32'(px_a[8]), 32'hFFFFFF);
        chk("f3_chk_after_sel", 32'(px_a[58]), 32'hFFFFFF);
        chk("f3_chk_l3_x2", 32'(px_a[74]), 32'h0);
        chk("f3_chk_l3_x12", 32'(px_a[84]), 32'hFFFFFF);
        // frame 4: solid, enable dropped at clk 30
        grab(-1, 2'd3, 30, 1'b0);
        chk("f4_solid_x0", 32'(px_a[0]), 32'hFF0000);
        chk("f4_solid_l3_x15", 32'(px_a[87]), 32'hFF0000);
        chk("f4_nde", nde, 64);
        chk("f4_nfs", nfs, 1);
        chk("f4_hs_last_line", 32'(hs_a[186]), 32'h1);
        chk("f4_nvs", nvs, 48);
        // frame 5 slot: idle
        grab(-1, 2'd3, -1, 1'b0);
        chk("f5_nde", nde, 0);
        chk("f5_nfs", nfs, 0);
        chk("f5_nhs", nhs, 0);
        chk("f5_nvs", nvs, 0);
        chk("f5_npx", npx, 0);
        // re-enable
        enable = 1'b1;
        @(negedge clk);
        chk("reen_pre_outs", outs(), 32'h0);
        grab(-1, 2'd3, -1, 1'b1);
        chk("f6_fs_first", 32'(fs_a[0]), 32'h1);
        chk("f6_de_first", 32'(de_a[0]), 32'h1);
        chk("f6_px_first", 32'(px_a[0]), 32'hFF0000);
        chk("f6_nde", nde, 64);
        // async reset mid-line 2
        repeat (58) @(negedge clk);
        chk("pre_reset_de", 32'(de_out), 32'h1);
        chk("pre_reset_px", 32'(pixel_out), 32'hFF0000);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", outs(), 32'h0);
        pattern_sel = 2'd1;
        repeat (3) @(negedge clk);
        chk("reset_hold_outs", outs(), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_pre_outs", outs(), 32'h0);
        grab(-1, 2'd1, -1, 1'b1);
        chk("f8_fs_first", 32'(fs_a[0]), 32'h1);
        chk("f8_nfs", nfs, 1);
        chk("f8_ramp_x5", 32'(px_a[5]), 32'h050505);
        chk("f8_hs_first", hs_first, 18);
        chk("f8_nde", nde, 64);
`ifdef VIDEO_PATTERN_TX_FRAME_CNT_EN
        chk("fcnt_frame0", 32'(fc0), 32'h0);
        grab(-1, 2'd1, -1, 1'b1);
        chk("fcnt_frame1", 32'(fc0), 32'h1);
        grab(-1, 2'd1, -1, 1'b1);
        chk("fcnt_frame2", 32'(fc0), 32'h2);
        chk("fcnt_ramp_first", 32'(px_a[0]), 32'h020202);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/video_pattern_tx.md
Name: video_pattern_tx

Overview:
- Video source block: generates DE/HSYNC/VSYNC timing and a selectable 24-bit RGB test pattern on the same pixel-stream interface that processing blocks consume.
- Transmit-side counterpart of the file-driven HDMI input model. Used on hardware when no camera or HDMI source is attached, and in simulation as a synthesizable stimulus for processing chains.

Parameters:
- H_ACTIVE, 64: active pixels per line. Must be a multiple of 8 and at least 8.
- H_FP, 4: horizontal front porch, in pixels.
- H_SYNC, 8: horizontal sync width, in pixels.
- H_BP, 4: horizontal back porch, in pixels.
- V_ACTIVE, 32: active lines per frame.
- V_FP, 2: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 2: vertical back porch, in lines.
- SOLID_COLOR, 24'hFF0000: RGB value output by pattern 3.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request. Sampled only at frame boundary.
- pattern_sel  in  2  0 = colour bars, 1 = grey ramp, 2 = checkerboard, 3 = solid.
- de_out  out  1  data enable.
- h_sync_out  out  1  horizontal sync, active high.
- v_sync_out  out  1  vertical sync, active high.
- pixel_out  out  24  {R[23:16], G[15:8], B[7:0]}.
- frame_start  out  1  one-cycle pulse, coincident with the first output cycle of each frame.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments on h_cnt wrap, runs 0..V_TOTAL-1, and wraps to 0.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- HSYNC window: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, asserted on every line including blanking lines.
- VSYNC window: V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. VSYNC changes only on cycles where h_cnt == 0.
- Output registers: all outputs are registered. Latency is exactly 1 clk from counter state to outputs, and de/hs/vs/pixel/frame_start are mutually aligned.
- Reset (async assert, sync release): all outputs 0; h_cnt = 0, v_cnt = 0; state IDLE; pattern register = 0.
- FSM, IDLE: counters held at 0, all outputs 0. Go to RUN when enable == 1.
  - On this transition, pattern_sel is latched.
  - The first RUN cycle presents h_cnt = 0, v_cnt = 0.
  - frame_start pulses with that first output cycle.
- FSM, RUN: counters advance every clk.
  - At the last cycle of a frame (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1), if enable == 0 go to IDLE.
  - Otherwise stay in RUN, wrap to (0,0), re-latch pattern_sel, and pulse frame_start.
- Enable timing: deasserting enable mid-frame has no effect until the frame completes. No partial frames are ever emitted.
- Pattern changes: changing pattern_sel mid-frame has no effect until the next frame.
- Pixel values use x = h_cnt and y = v_cnt at the active position. pixel_out = 0 whenever de_out = 0.
- Pattern 0, colour bars: 8 bars, each H_ACTIVE/8 pixels wide. Bar index comes from a bar counter reset at h_cnt = 0 (no divider).
  - Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Pattern 1, grey ramp: R = G = B = x[7:0], wrapping mod 256.
- Pattern 2, checkerboard: (x[3] ^ y[3]) ? FFFFFF : 000000.
- Pattern 3, solid: SOLID_COLOR.

Optional Feature:
- Macro: VIDEO_PATTERN_TX_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_cnt (out, 16 bits). It resets to 0, increments by 1 on each frame_start after the first, and wraps at 65535 to 0.
  - Ramp pattern becomes R = G = B = (x + frame_cnt)[7:0], giving a scrolling ramp.
- When undefined: no frame_cnt port, no counter logic, and the ramp is static.

Test Plan:
Common parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8). One frame = 192 clk.
1. Reset release, then enable=1 with pattern_sel=1 held:
   - frame_start pulses every 192 clk.
   - de_out is high for 16 clk per line on 4 lines (64 DE cycles per frame).
   - h_sync_out is high for 3 clk starting 18 clk after DE rises, on all 8 lines.
   - v_sync_out is high for 48 clk, starting 120 clk after frame_start.
2. pattern_sel=0: pixel_out on each active line is 2 clk of FFFFFF, then 2 of FFFF00, ..., then 2 of 000000. pixel_out = 0 in blanking.
3. pattern_sel switched from 2 to 3 at clk 50 of a frame: the rest of that frame stays checkerboard. The next frame is all SOLID_COLOR (FF0000).
4. enable dropped at clk 30 of a frame: the frame completes all 192 clk, then all outputs stay 0. Re-enabling restarts with frame_start on the first output cycle.
5. rst_n asserted mid-line (clk 10 of line 2): all outputs go 0 immediately, without waiting for clk. After release with enable=1, the first frame starts clean at (0,0).
6. With VIDEO_PATTERN_TX_FRAME_CNT_EN and pattern 1: frame_cnt reads 0, 1, 2 over three frames. The first active pixel of frame 2 = 020202.
